// File: rtl/count_pkg.sv
// Shared types, range constants and the next-count model for the 2..10 up/down counter.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2
    } chk_state_e;

    localparam int CHK_MIN_VAL = 2;
    localparam int CHK_MAX_VAL = 10;
    // Internal width of the model; callers zero-extend and truncate around it.
    localparam int CHK_DW      = 8;

    function automatic logic [CHK_DW-1:0] count_next(
        input logic [CHK_DW-1:0] q,
        input logic              resetn,
        input logic              load,
        input logic              up_down,
        input logic [CHK_DW-1:0] din,
        input logic [CHK_DW-1:0] min_v = CHK_DW'(CHK_MIN_VAL),
        input logic [CHK_DW-1:0] max_v = CHK_DW'(CHK_MAX_VAL)
    );
        logic [CHK_DW-1:0] r;
        if (!resetn)
            r = '0;
        else if (!load)
            r = din;
        else if (up_down)
            r = (q >= max_v) ? min_v : q + 1'b1;
        else
            r = (q <= min_v) ? max_v : q - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/count_checker.sv
// In-line observer for the loadable 2..10 up/down counter: predicts each next count and flags mismatches.
// Optional coverage counters are built when COUNT_CHK_COVER_EN is defined.
module count_checker
    import count_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = CHK_MIN_VAL,
    parameter int MAX_VAL = CHK_MAX_VAL,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             obs_resetn,
    input  logic             obs_load,
    input  logic             obs_up_down,
    input  logic [WIDTH-1:0] obs_din,
    input  logic [WIDTH-1:0] obs_count,
    output logic [WIDTH-1:0] exp_count,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
`ifdef COUNT_CHK_COVER_EN
    ,
    output logic [CNT_W-1:0] wrap_up_cnt,
    output logic [CNT_W-1:0] wrap_dn_cnt,
    output logic [CNT_W-1:0] load_cnt
`endif
);

    chk_state_e       r_state, w_state_nxt;
    logic             r_exp_valid, w_exp_valid_nxt;
    logic [WIDTH-1:0] r_exp;
    logic             r_mismatch;
    logic             r_sticky;
    logic [WIDTH-1:0] r_first_exp, r_first_got;
    logic [WIDTH-1:0] w_pred;
    logic             w_cmp, w_miss;

    // One-step prediction from the observed value, so a single fault never cascades.
    assign w_pred = WIDTH'(count_next(CHK_DW'(obs_count), obs_resetn, obs_load, obs_up_down,
                                      CHK_DW'(obs_din), CHK_DW'(MIN_VAL), CHK_DW'(MAX_VAL)));

    assign w_cmp  = (r_state == CHECK) && r_exp_valid;
    // Case-inequality so X/Z on the observed count is reported as an error.
    assign w_miss = w_cmp && (obs_count !== r_exp);

    always_comb begin
        w_state_nxt     = r_state;
        w_exp_valid_nxt = r_exp_valid;
        case (r_state)
            IDLE: begin
                if (chk_en)
                    w_state_nxt = ARM;
            end
            ARM: begin
                w_exp_valid_nxt = 1'b1;
                w_state_nxt     = CHECK;
            end
            CHECK: begin
                if (!chk_en) begin
                    w_state_nxt     = IDLE;
                    w_exp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_exp_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_exp_valid <= 1'b0;
            r_exp       <= '0;
            r_mismatch  <= 1'b0;
            r_sticky    <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_valid <= w_exp_valid_nxt;
            r_exp       <= w_pred;
            r_mismatch  <= w_miss;
            if (w_miss) begin
                r_sticky <= 1'b1;
                if (!r_sticky) begin
                    r_first_exp <= r_exp;
                    r_first_got <= obs_count;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
        .i_clock (clock),
        .i_clear (reset),
        .i_inc   (w_cmp),
        .o_count (chk_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .i_clock (clock),
        .i_clear (reset),
        .i_inc   (w_miss),
        .o_count (err_cnt)
    );

`ifdef COUNT_CHK_COVER_EN
    logic w_in_check, w_step, w_wrap_up, w_wrap_dn, w_load;

    assign w_in_check = (r_state == CHECK);
    assign w_step     = obs_resetn && obs_load;
    assign w_wrap_up  = w_in_check && w_step &&  obs_up_down && (obs_count == WIDTH'(MAX_VAL));
    assign w_wrap_dn  = w_in_check && w_step && !obs_up_down && (obs_count == WIDTH'(MIN_VAL));
    assign w_load     = w_in_check && obs_resetn && !obs_load;

    sat_counter #(.CNT_W(CNT_W)) u_wrap_up_cnt (
        .i_clock (clock), .i_clear (reset), .i_inc (w_wrap_up), .o_count (wrap_up_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_wrap_dn_cnt (
        .i_clock (clock), .i_clear (reset), .i_inc (w_wrap_dn), .o_count (wrap_dn_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .i_clock (clock), .i_clear (reset), .i_inc (w_load), .o_count (load_cnt)
    );
`endif

    assign exp_count  = r_exp;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_sticky;
    assign first_exp  = r_first_exp;
    assign first_got  = r_first_got;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: a driver models the observed counter and checker and queues expectations.
module tb_count_checker;

    localparam int W    = 4;
    localparam int CW   = 4;
    localparam int MINV = 2;
    localparam int MAXV = 10;

    logic          clock = 1'b0;
    logic          reset, chk_en, obs_resetn, obs_load, obs_up_down;
    logic [W-1:0]  obs_din, obs_count;
    logic [W-1:0]  exp_count, first_exp, first_got;
    logic          mismatch, err_sticky;
    logic [CW-1:0] err_cnt, chk_cnt;
`ifdef COUNT_CHK_COVER_EN
    logic [CW-1:0] wrap_up_cnt, wrap_dn_cnt, load_cnt;
`endif

    always #5 clock = ~clock;

    count_checker #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .chk_en(chk_en),
        .obs_resetn(obs_resetn), .obs_load(obs_load), .obs_up_down(obs_up_down),
        .obs_din(obs_din), .obs_count(obs_count),
        .exp_count(exp_count), .mismatch(mismatch), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt), .first_exp(first_exp), .first_got(first_got)
`ifdef COUNT_CHK_COVER_EN
        , .wrap_up_cnt(wrap_up_cnt), .wrap_dn_cnt(wrap_dn_cnt), .load_cnt(load_cnt)
`endif
    );

    typedef struct packed {
        logic [W-1:0]  exp_count;
        logic          mismatch;
        logic          sticky;
        logic [CW-1:0] ec, cc;
        logic [W-1:0]  fe, fg;
        logic [CW-1:0] wu, wd, lc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: observed counter plus checker.
    logic [W-1:0]  cnt;
    int            m_st;
    logic [W-1:0]  m_exp, m_fe, m_fg;
    logic          m_mm, m_sticky;
    logic [CW-1:0] m_ec, m_cc, m_wu, m_wd, m_lc;

    function automatic logic [W-1:0] ref_nxt(input logic [W-1:0] v, input logic rn, ld, ud,
                                             input logic [W-1:0] d);
        if (!rn) return 4'd0;
        if (!ld) return d;
        if (ud)  return (v >= 4'd10) ? 4'd2 : v + 4'd1;
        return (v <= 4'd2) ? 4'd10 : v - 4'd1;
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // frc: -1 drive the modelled count, -2 drive X, otherwise drive that value (counter glitch).
    task automatic step(input logic en, rst, rn, ld, ud, input logic [W-1:0] d, input int frc = -1);
        logic [W-1:0] o;
        logic         miss;
        exp_t         e;
        @(negedge clock);
        if (frc == -2)      o = 4'bxxxx;
        else if (frc >= 0)  o = 4'(frc);
        else                o = cnt;
        reset = rst; chk_en = en; obs_resetn = rn; obs_load = ld; obs_up_down = ud;
        obs_din = d; obs_count = o;
        if (rst) begin
            m_st = 0; m_exp = '0; m_mm = 0; m_sticky = 0; m_ec = '0; m_cc = '0;
            m_fe = '0; m_fg = '0; m_wu = '0; m_wd = '0; m_lc = '0;
        end else begin
            case (m_st)
                0: begin m_mm = 0; if (en) m_st = 1; end
                1: begin m_mm = 0; m_st = 2; end
                default: begin
                    miss = (o !== m_exp);
                    m_mm = miss;
                    m_cc = sat(m_cc);
                    if (miss) begin
                        m_ec = sat(m_ec);
                        if (!m_sticky) begin m_fe = m_exp; m_fg = o; end
                        m_sticky = 1;
                    end
                    if (rn && ld && ud && o == 4'd10)  m_wu = sat(m_wu);
                    if (rn && ld && !ud && o == 4'd2)  m_wd = sat(m_wd);
                    if (rn && !ld)                     m_lc = sat(m_lc);
                    if (!en) m_st = 0;
                end
            endcase
            m_exp = ref_nxt(o, rn, ld, ud, d);
        end
        cnt = (frc == -2) ? 4'd0 : ref_nxt(o, rn, ld, ud, d);
        e = '{exp_count: m_exp, mismatch: m_mm, sticky: m_sticky, ec: m_ec, cc: m_cc,
              fe: m_fe, fg: m_fg, wu: m_wu, wd: m_wd, lc: m_lc};
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Monitor: every edge the DUT presents a full output snapshot; compare against the queued one.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("exp_count",  exp_count,       e.exp_count);
            chk("mismatch",   {3'b0, mismatch},   {3'b0, e.mismatch});
            chk("err_sticky", {3'b0, err_sticky}, {3'b0, e.sticky});
            chk("err_cnt",    err_cnt,   e.ec);
            chk("chk_cnt",    chk_cnt,   e.cc);
            chk("first_exp",  first_exp, e.fe);
            chk("first_got",  first_got, e.fg);
`ifdef COUNT_CHK_COVER_EN
            chk("wrap_up_cnt", wrap_up_cnt, e.wu);
            chk("wrap_dn_cnt", wrap_dn_cnt, e.wd);
            chk("load_cnt",    load_cnt,    e.lc);
`endif
        end
    end

    initial begin
        reset = 1; chk_en = 0; obs_resetn = 1; obs_load = 1; obs_up_down = 1;
        obs_din = '0; obs_count = '0; cnt = '0;
        m_st = 0; m_exp = '0; m_mm = 0; m_sticky = 0; m_ec = '0; m_cc = '0;
        m_fe = '0; m_fg = '0; m_wu = '0; m_wd = '0; m_lc = '0;

        // Reset state
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1, 0);

        // Reset-and-count: counter held in reset, then up through 0,1,2..10,2,3
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 1, 1, 1, 0);

        // Down wrap: load 3, then 3,2,10,9
        step(1, 1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0, 3);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, 0);

        // Injected fault: 5 up should give 6, counter shows 7; 7 up to 8 is then clean
        step(1, 1, 1, 1, 1, 0);
        step(1, 0, 1, 0, 1, 5);
        step(1, 0, 1, 0, 1, 5);
        step(1, 0, 1, 1, 1, 0);
        step(1, 0, 1, 1, 1, 0, 7);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 0);

        // Out-of-range loads: 15 up gives 2, 0 down gives 10
        step(1, 0, 1, 0, 1, 15);
        step(1, 0, 1, 1, 1, 0);
        step(1, 0, 1, 1, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0);

        // Saturation: counter held in reset but observed stuck at 5 -> 20 errors
        step(1, 1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 0, 5);
        // Reset mid-CHECK
        step(1, 1, 0, 1, 1, 0, 5);
        step(0, 1, 1, 1, 1, 0);

        // X on the observed count is an error
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0, -2);
        step(0, 0, 0, 1, 1, 0);

        // Enable gating: garbage while disabled, then re-enable
        step(0, 1, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0, 9);
        step(0, 0, 1, 0, 0, 4, 15);
        step(0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 6);
        step(1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 1, 0);
        // Enable drops in the same cycle as a mismatch
        step(0, 0, 1, 1, 1, 0, 3);
        step(0, 0, 1, 1, 1, 0);

        @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Synthesizable in-line observer (reader side) for the 4-bit loadable, truncated up-down counter (range 2..10).
- Samples the counter's control inputs and `count` output every clock.
- Predicts each next `count` with a golden model and flags mismatches.
- Instantiated beside the counter in the top, so self-checking also works in emulation, where no class-based scoreboard exists.

Parameters:
- WIDTH, 4: counter data width.
- MIN_VAL, 2: lowest in-range count.
- MAX_VAL, 10: highest in-range count.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high checker reset.
- chk_en  in  1  checking enable.
- obs_resetn  in  1  observed counter reset (active low).
- obs_load  in  1  observed load (active low).
- obs_up_down  in  1  observed direction (1 = up).
- obs_din  in  WIDTH  observed load data.
- obs_count  in  WIDTH  observed counter output.
- exp_count  out  WIDTH  predicted value for the next sample.
- mismatch  out  1  one-cycle error pulse.
- err_sticky  out  1  set on first error, cleared only by reset.
- err_cnt  out  CNT_W  saturating error count.
- chk_cnt  out  CNT_W  saturating count of compares performed.
- first_exp  out  WIDTH  expected value at the first error.
- first_got  out  WIDTH  observed value at the first error.

Behaviour:
- One clock, `clock`; reset is synchronous and active-high on `reset`; all state updates on the rising edge of `clock`.
- Reset values:
  - All outputs 0; FSM = IDLE; `exp_valid` = 0.
- Golden model `nxt(q, ctl)`, with priority in this order:
  1. `obs_resetn` == 0 gives 0.
  2. `obs_load` == 0 gives `obs_din` (any value, not clamped).
  3. Up: if q >= MAX_VAL then MIN_VAL, else q+1.
  4. Down: if q <= MIN_VAL then MAX_VAL, else q-1.
  - Consequence: out-of-range values wrap immediately (0 up gives 1; 0 down gives 10; 15 up gives 2).
- Every edge: `exp_count` <= `nxt(obs_count, ctl)`, using the values sampled at that edge.
  - The prediction is one-step from the observed value, so a single fault produces exactly one error, with no cascade.
- Compare timing:
  - The counter updates at edge k; the checker samples that result at edge k+1 and compares it with the `exp_count` registered at edge k.
  - `mismatch` is registered and high for exactly the cycle after edge k+1.
- FSM:
  - IDLE: no compares. Go to ARM when `chk_en` = 1.
  - ARM: loads `exp_count`, sets `exp_valid`. Go to CHECK next cycle.
  - CHECK:
    - Each edge: compare, and `chk_cnt` +1.
    - On mismatch: `err_cnt` +1 and `err_sticky` set. If `err_sticky` was 0, capture `first_exp` and `first_got`.
    - Go to IDLE when `chk_en` = 0; `exp_valid` is cleared.
- Statistics counters saturate at all-ones (2^CNT_W-1); they never wrap.
- `chk_en` dropping in the same cycle as a mismatch: the compare still counts, then the FSM goes to IDLE.
- `reset` mid-CHECK: everything returns to reset values next cycle, including the sticky flag and captures.
- X/Z on `obs_count` in CHECK counts as a mismatch (use case-inequality).

Optional Feature:
- Macro `COUNT_CHK_COVER_EN`.
- When defined, adds three saturating CNT_W outputs, incremented only in CHECK:
  - `wrap_up_cnt`: predicted MAX_VAL to MIN_VAL step.
  - `wrap_dn_cnt`: predicted MIN_VAL to MAX_VAL step.
  - `load_cnt`: `obs_load` == 0 with `obs_resetn` == 1.
- All three reset to 0.
- When undefined, these ports and their logic are absent; the checking behaviour is identical either way.

Decomposition:
- count_pkg gains:
  - enum `chk_state_e` {IDLE, ARM, CHECK};
  - constants CHK_MIN_VAL = 2, CHK_MAX_VAL = 10;
  - pure function `count_next(q, resetn, load, up_down, din)`, shared with the class-based reference model so both agree.
- One sub-module: `sat_counter` (CNT_W, inc, clear), reused for `err_cnt`, `chk_cnt` and the optional coverage counters.

Test Plan:
- Reset-and-count: `chk_en` = 1, counter reset then up for 12 cycles, with count sequence 0,1,2..10,2 → `mismatch` never asserted; `chk_cnt` = 12; `err_cnt` = 0.
- Down wrap: load 3, then down for 3 cycles (3,2,10,9) → no errors; with the cover macro, `wrap_dn_cnt` = 1 and `load_cnt` = 1.
- Injected fault: the bench forces `obs_count` = 7 where 6 is expected → `mismatch` pulses once, exactly one cycle after the sample; `err_cnt` = 1; `first_exp` = 6; `first_got` = 7; the next step (7 up, expected 8) is clean.
- Out-of-range load: load 15, then up → expect 2; load 0, then down → expect 10; no mismatch.
- Saturation and reset: CNT_W = 4 with 20 forced errors → `err_cnt` holds at 15; assert `reset` mid-CHECK → next cycle all outputs are 0 and the FSM is in IDLE.
- Enable gating: `chk_en` = 0 with garbage on `obs_count` → no `mismatch` and `chk_cnt` stays 0; re-enable → ARM for one cycle, then compares resume.
